mem_arbiter: RTL and testbench

Two-requester AXI read arbiter that shares one memory port between the instruction fetch path (instruction cache) and the data path (load/store unit). It accepts single-beat read addresses from both requesters and allows exactly one read outstanding on the memory side. It routes each read response back to the requester that issued it. Data-side writes pass straight through to the memory port.

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/arbiter2.sv | 42 ++++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester AXI read arbiter.
package mem_arbiter_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    IPORT = 1'b0,
    DPORT = 1'b1
  } arb_port_t;
endpackage

// File: rtl/arbiter2.sv
// Two-input one-hot grant. Bit 0 is the instruction port, bit 1 the data port.
// RV32_ARB_ROUND_ROBIN_EN selects round-robin; otherwise the data port wins conflicts.
module arbiter2
  import mem_arbiter_pkg::*;
(
`ifdef RV32_ARB_ROUND_ROBIN_EN
  input  logic       aclk,
  input  logic       aresetn,
`endif
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_grant
);

  logic [1:0] w_conflict_grant;

`ifdef RV32_ARB_ROUND_ROBIN_EN
  arb_port_t r_last;

  // On a conflict the port that did not win the previous grant goes first.
  assign w_conflict_grant = (r_last == IPORT) ? 2'b10 : 2'b01;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_last <= IPORT;
    end else if (|o_grant) begin
      r_last <= o_grant[1] ? DPORT : IPORT;
    end
  end
`else
  // Fetch may starve behind back-to-back loads; the pipeline stalls fetch then anyway.
  assign w_conflict_grant = 2'b10;
`endif

  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      o_grant = (&i_req) ? w_conflict_grant : i_req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one AXI memory port between instruction and data requesters, one read outstanding.
// Arbitration policy selected by RV32_ARB_ROUND_ROBIN_EN (see arbiter2).
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              aclk,
  input  logic              aresetn,
  // instruction requester (read only)
  input  logic              i_ip_arvalid,
  output logic              o_ip_arready,
  input  logic [ADDR_W-1:0] i_ip_araddr,
  input  logic [2:0]        i_ip_arprot,
  output logic              o_ip_rvalid,
  input  logic              i_ip_rready,
  output logic [DATA_W-1:0] o_ip_rdata,
  output logic [1:0]        o_ip_rresp,
  output logic              o_ip_awready,
  output logic              o_ip_wready,
  output logic              o_ip_bvalid,
  // data requester
  input  logic              i_dp_arvalid,
  output logic              o_dp_arready,
  input  logic [ADDR_W-1:0] i_dp_araddr,
  input  logic [2:0]        i_dp_arprot,
  output logic              o_dp_rvalid,
  input  logic              i_dp_rready,
  output logic [DATA_W-1:0] o_dp_rdata,
  output logic [1:0]        o_dp_rresp,
  input  logic              i_dp_awvalid,
  output logic              o_dp_awready,
  input  logic [ADDR_W-1:0] i_dp_awaddr,
  input  logic [2:0]        i_dp_awprot,
  input  logic              i_dp_wvalid,
  output logic              o_dp_wready,
  input  logic [DATA_W-1:0] i_dp_wdata,
  input  logic [3:0]        i_dp_wstrb,
  output logic              o_dp_bvalid,
  input  logic              i_dp_bready,
  output logic [1:0]        o_dp_bresp,
  // shared memory port
  output logic              o_mem_arvalid,
  input  logic              i_mem_arready,
  output logic [ADDR_W-1:0] o_mem_araddr,
  output logic [2:0]        o_mem_arprot,
  input  logic              i_mem_rvalid,
  output logic              o_mem_rready,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic [1:0]        i_mem_rresp,
  output logic              o_mem_awvalid,
  input  logic              i_mem_awready,
  output logic [ADDR_W-1:0] o_mem_awaddr,
  output logic [2:0]        o_mem_awprot,
  output logic              o_mem_wvalid,
  input  logic              i_mem_wready,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_wstrb,
  input  logic              i_mem_bvalid,
  output logic              o_mem_bready,
  input  logic [1:0]        i_mem_bresp
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  arb_port_t         r_sel;
  logic              r_arvalid;
  logic [ADDR_W-1:0] r_araddr;
  logic [2:0]        r_arprot;
  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  logic              w_idle;
  logic              w_sel_rready;

  assign w_idle       = (r_state == IDLE);
  assign w_req        = {i_dp_arvalid, i_ip_arvalid};
  assign w_sel_rready = (r_sel == DPORT) ? i_dp_rready : i_ip_rready;

  arbiter2 u_arb (
`ifdef RV32_ARB_ROUND_ROBIN_EN
    .aclk    (aclk),
    .aresetn (aresetn),
`endif
    .i_req   (w_req),
    .i_en    (w_idle),
    .o_grant (w_grant)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_ip_arready = 1'b0;
    o_dp_arready = 1'b0;
    o_ip_rvalid  = 1'b0;
    o_dp_rvalid  = 1'b0;
    o_mem_rready = 1'b0;
    case (r_state)
      IDLE: begin
        o_ip_arready = w_grant[0];
        o_dp_arready = w_grant[1];
        if (|w_grant) w_state_nxt = ADDR;
      end
      ADDR: begin
        if (i_mem_arready) w_state_nxt = DATA;
      end
      DATA: begin
        // rready comes only from the requester, so there is no loop through rvalid.
        o_mem_rready = w_sel_rready;
        o_ip_rvalid  = (r_sel == IPORT) && i_mem_rvalid;
        o_dp_rvalid  = (r_sel == DPORT) && i_mem_rvalid;
        if (i_mem_rvalid && w_sel_rready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_arprot  <= '0;
      r_sel     <= DPORT;
    end else if (|w_grant) begin
      r_arvalid <= 1'b1;
      r_sel     <= w_grant[1] ? DPORT : IPORT;
      r_araddr  <= w_grant[1] ? i_dp_araddr : i_ip_araddr;
      r_arprot  <= w_grant[1] ? i_dp_arprot : i_ip_arprot;
    end else if ((r_state == ADDR) && i_mem_arready) begin
      r_arvalid <= 1'b0;
    end
  end

  assign o_mem_arvalid = r_arvalid;
  assign o_mem_araddr  = r_araddr;
  assign o_mem_arprot  = r_arprot;

  assign o_ip_rdata = i_mem_rdata;
  assign o_ip_rresp = i_mem_rresp;
  assign o_dp_rdata = i_mem_rdata;
  assign o_dp_rresp = i_mem_rresp;

  assign o_ip_awready = 1'b0;
  assign o_ip_wready  = 1'b0;
  assign o_ip_bvalid  = 1'b0;

  // Writes bypass the read FSM; the memory owns write/read ordering.
  assign o_mem_awvalid = i_dp_awvalid;
  assign o_mem_awaddr  = i_dp_awaddr;
  assign o_mem_awprot  = i_dp_awprot;
  assign o_dp_awready  = i_mem_awready;
  assign o_mem_wvalid  = i_dp_wvalid;
  assign o_mem_wdata   = i_dp_wdata;
  assign o_mem_wstrb   = i_dp_wstrb;
  assign o_dp_wready   = i_mem_wready;
  assign o_dp_bvalid   = i_mem_bvalid;
  assign o_dp_bresp    = i_mem_bresp;
  assign o_mem_bready  = i_dp_bready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle, directed cases plus random traffic.
module tb_mem_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        i_ip_arvalid, o_ip_arready, o_ip_rvalid, i_ip_rready;
  logic [31:0] i_ip_araddr, o_ip_rdata;
  logic [2:0]  i_ip_arprot;
  logic [1:0]  o_ip_rresp;
  logic        o_ip_awready, o_ip_wready, o_ip_bvalid;
  logic        i_dp_arvalid, o_dp_arready, o_dp_rvalid, i_dp_rready;
  logic [31:0] i_dp_araddr, o_dp_rdata;
  logic [2:0]  i_dp_arprot;
  logic [1:0]  o_dp_rresp;
  logic        i_dp_awvalid, o_dp_awready, i_dp_wvalid, o_dp_wready, o_dp_bvalid, i_dp_bready;
  logic [31:0] i_dp_awaddr, i_dp_wdata;
  logic [2:0]  i_dp_awprot;
  logic [3:0]  i_dp_wstrb;
  logic [1:0]  o_dp_bresp;
  logic        o_mem_arvalid, i_mem_arready, i_mem_rvalid, o_mem_rready;
  logic [31:0] o_mem_araddr, i_mem_rdata;
  logic [2:0]  o_mem_arprot;
  logic [1:0]  i_mem_rresp;
  logic        o_mem_awvalid, i_mem_awready, o_mem_wvalid, i_mem_wready, i_mem_bvalid, o_mem_bready;
  logic [31:0] o_mem_awaddr, o_mem_wdata;
  logic [2:0]  o_mem_awprot;
  logic [3:0]  o_mem_wstrb;
  logic [1:0]  i_mem_bresp;

  mem_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_ip_arvalid(i_ip_arvalid), .o_ip_arready(o_ip_arready), .i_ip_araddr(i_ip_araddr),
    .i_ip_arprot(i_ip_arprot), .o_ip_rvalid(o_ip_rvalid), .i_ip_rready(i_ip_rready),
    .o_ip_rdata(o_ip_rdata), .o_ip_rresp(o_ip_rresp), .o_ip_awready(o_ip_awready),
    .o_ip_wready(o_ip_wready), .o_ip_bvalid(o_ip_bvalid),
    .i_dp_arvalid(i_dp_arvalid), .o_dp_arready(o_dp_arready), .i_dp_araddr(i_dp_araddr),
    .i_dp_arprot(i_dp_arprot), .o_dp_rvalid(o_dp_rvalid), .i_dp_rready(i_dp_rready),
    .o_dp_rdata(o_dp_rdata), .o_dp_rresp(o_dp_rresp),
    .i_dp_awvalid(i_dp_awvalid), .o_dp_awready(o_dp_awready), .i_dp_awaddr(i_dp_awaddr),
    .i_dp_awprot(i_dp_awprot), .i_dp_wvalid(i_dp_wvalid), .o_dp_wready(o_dp_wready),
    .i_dp_wdata(i_dp_wdata), .i_dp_wstrb(i_dp_wstrb), .o_dp_bvalid(o_dp_bvalid),
    .i_dp_bready(i_dp_bready), .o_dp_bresp(o_dp_bresp),
    .o_mem_arvalid(o_mem_arvalid), .i_mem_arready(i_mem_arready), .o_mem_araddr(o_mem_araddr),
    .o_mem_arprot(o_mem_arprot), .i_mem_rvalid(i_mem_rvalid), .o_mem_rready(o_mem_rready),
    .i_mem_rdata(i_mem_rdata), .i_mem_rresp(i_mem_rresp),
    .o_mem_awvalid(o_mem_awvalid), .i_mem_awready(i_mem_awready), .o_mem_awaddr(o_mem_awaddr),
    .o_mem_awprot(o_mem_awprot), .o_mem_wvalid(o_mem_wvalid), .i_mem_wready(i_mem_wready),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb), .i_mem_bvalid(i_mem_bvalid),
    .o_mem_bready(o_mem_bready), .i_mem_bresp(i_mem_bresp)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: one read in flight, owner, address phase done or not.
  bit          m_on = 1'b0, m_busy = 1'b0, m_acc = 1'b0, m_owner_dp = 1'b0, m_last_dp = 1'b0;
  logic [31:0] m_addr = '0;
  logic [2:0]  m_prot = '0;
  // Handshakes observed before the coming edge.
  bit          h_ip_ar, h_dp_ar, h_mem_ar, h_mem_r, h_rst;
  // Bench memory and mode.
  bit          rand_en = 1'b0, mem_hold = 1'b0, mem_pend = 1'b0;
  logic [31:0] mem_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Grant rule: {dp, ip}; a lone request wins, a conflict follows the policy.
  function automatic logic [1:0] policy(input bit ip, input bit dp, input bit last_dp);
    if (ip && dp) begin
`ifdef RV32_ARB_ROUND_ROBIN_EN
      return last_dp ? 2'b01 : 2'b10;
`else
      return 2'b10;
`endif
    end
    return {dp, ip};
  endfunction

  task automatic settle();
    logic [1:0] e_gnt;
    bit rd, own_rr;
    @(negedge aclk);
    e_gnt  = m_busy ? 2'b00 : policy(i_ip_arvalid, i_dp_arvalid, m_last_dp);
    rd     = m_busy && m_acc;
    own_rr = m_owner_dp ? i_dp_rready : i_ip_rready;
    if (m_on) begin
      chk("ip_arready", 32'(o_ip_arready), 32'(e_gnt[0]));
      chk("dp_arready", 32'(o_dp_arready), 32'(e_gnt[1]));
      chk("mem_arvalid", 32'(o_mem_arvalid), 32'(m_busy && !m_acc));
      if (m_busy && !m_acc) begin
        chk("mem_araddr", o_mem_araddr, m_addr);
        chk("mem_arprot", 32'(o_mem_arprot), 32'(m_prot));
      end
      chk("mem_rready", 32'(o_mem_rready), 32'(rd && own_rr));
      chk("ip_rvalid", 32'(o_ip_rvalid), 32'(rd && !m_owner_dp && i_mem_rvalid));
      chk("dp_rvalid", 32'(o_dp_rvalid), 32'(rd && m_owner_dp && i_mem_rvalid));
      if (rd && i_mem_rvalid) begin
        chk("sel_rdata", m_owner_dp ? o_dp_rdata : o_ip_rdata, i_mem_rdata);
        chk("sel_rresp", 32'(m_owner_dp ? o_dp_rresp : o_ip_rresp), 32'(i_mem_rresp));
      end
      chk("ip_tieoff", {29'd0, o_ip_awready, o_ip_wready, o_ip_bvalid}, 32'd0);
      chk("aw_fwd", {o_mem_awvalid, o_mem_awprot, o_mem_awaddr[27:0]},
          {i_dp_awvalid, i_dp_awprot, i_dp_awaddr[27:0]});
      chk("awaddr_fwd", o_mem_awaddr, i_dp_awaddr);
      chk("w_fwd", o_mem_wdata, i_dp_wdata);
      chk("wctl_fwd", {27'd0, o_mem_wvalid, o_mem_wstrb}, {27'd0, i_dp_wvalid, i_dp_wstrb});
      chk("ready_back", {29'd0, o_dp_awready, o_dp_wready, o_mem_bready},
          {29'd0, i_mem_awready, i_mem_wready, i_dp_bready});
      chk("b_back", {29'd0, o_dp_bvalid, o_dp_bresp}, {29'd0, i_mem_bvalid, i_mem_bresp});
    end
    h_ip_ar  = i_ip_arvalid && o_ip_arready;
    h_dp_ar  = i_dp_arvalid && o_dp_arready;
    h_mem_ar = o_mem_arvalid && i_mem_arready;
    h_mem_r  = i_mem_rvalid && o_mem_rready;
    h_rst    = !aresetn;
    if (!aresetn) begin
      m_busy = 1'b0; m_acc = 1'b0; m_last_dp = 1'b0;
    end else if (!m_busy) begin
      if (|e_gnt) begin
        m_busy     = 1'b1;
        m_acc      = 1'b0;
        m_owner_dp = e_gnt[1];
        m_last_dp  = e_gnt[1];
        m_addr     = e_gnt[1] ? i_dp_araddr : i_ip_araddr;
        m_prot     = e_gnt[1] ? i_dp_arprot : i_ip_arprot;
      end
    end else if (!m_acc) begin
      if (i_mem_arready) m_acc = 1'b1;
    end else if (i_mem_rvalid && own_rr) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic rand_drive();
    if (!i_ip_arvalid && $urandom_range(0, 2) == 0) begin
      i_ip_arvalid = 1'b1;
      i_ip_araddr  = $urandom & 32'hFFFF_FFFC;
      i_ip_arprot  = 3'($urandom_range(0, 7));
    end
    if (!i_dp_arvalid && $urandom_range(0, 2) == 0) begin
      i_dp_arvalid = 1'b1;
      i_dp_araddr  = $urandom & 32'hFFFF_FFFC;
      i_dp_arprot  = 3'($urandom_range(0, 7));
    end
    i_ip_rready   = ($urandom_range(0, 3) != 0);
    i_dp_rready   = ($urandom_range(0, 3) != 0);
    i_dp_awvalid  = 1'($urandom_range(0, 1));
    i_dp_awaddr   = $urandom;
    i_dp_awprot   = 3'($urandom_range(0, 7));
    i_dp_wvalid   = 1'($urandom_range(0, 1));
    i_dp_wdata    = $urandom;
    i_dp_wstrb    = 4'($urandom_range(0, 15));
    i_dp_bready   = 1'($urandom_range(0, 1));
    i_mem_awready = 1'($urandom_range(0, 1));
    i_mem_wready  = 1'($urandom_range(0, 1));
    i_mem_bvalid  = 1'($urandom_range(0, 1));
    i_mem_bresp   = 2'($urandom_range(0, 3));
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
    if (h_ip_ar) i_ip_arvalid = 1'b0;
    if (h_dp_ar) i_dp_arvalid = 1'b0;
    if (h_rst) begin
      mem_pend     = 1'b0;
      i_mem_rvalid = 1'b0;
    end else begin
      if (h_mem_r) i_mem_rvalid = 1'b0;
      if (h_mem_ar) mem_pend = 1'b1;
      if (!i_mem_rvalid && mem_pend && (!rand_en || $urandom_range(0, 1) == 1)) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = rand_en ? $urandom : mem_data;
        i_mem_rresp  = rand_en ? 2'($urandom_range(0, 3)) : 2'b00;
        mem_pend     = 1'b0;
      end
    end
    i_mem_arready = rand_en ? ($urandom_range(0, 1) == 1) : !mem_hold;
    if (rand_en) rand_drive();
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    i_ip_arvalid = 1'b0;
    i_dp_arvalid = 1'b0;
    step();
    aresetn = 1'b1;
  endtask

  initial begin
    aresetn = 1'b0;
    {i_ip_arvalid, i_ip_rready, i_dp_arvalid, i_dp_rready} = '0;
    {i_ip_araddr, i_dp_araddr, i_ip_arprot, i_dp_arprot} = '0;
    {i_dp_awvalid, i_dp_awaddr, i_dp_awprot, i_dp_wvalid, i_dp_wdata, i_dp_wstrb, i_dp_bready} = '0;
    {i_mem_arready, i_mem_rvalid, i_mem_rdata, i_mem_rresp} = '0;
    {i_mem_awready, i_mem_wready, i_mem_bvalid, i_mem_bresp} = '0;
    repeat (2) step();
    m_on = 1'b1;
    settle();
    chk("rst_mem_arvalid", 32'(o_mem_arvalid), 32'd0);
    chk("rst_mem_araddr", o_mem_araddr, 32'd0);
    chk("rst_mem_arprot", 32'(o_mem_arprot), 32'd0);
    tick();
    aresetn = 1'b1;

    // Single instruction read, zero-wait memory.
    mem_data = 32'hDEAD_BEEF;
    i_ip_rready = 1'b1; i_dp_rready = 1'b1;
    i_ip_arvalid = 1'b1; i_ip_araddr = 32'h0000_0100; i_ip_arprot = 3'd0;
    settle(); chk("t1_ip_arready", 32'(o_ip_arready), 32'd1); tick();
    settle(); chk("t1_mem_araddr", o_mem_araddr, 32'h0000_0100);
    chk("t1_mem_arvalid", 32'(o_mem_arvalid), 32'd1); tick();
    settle(); chk("t1_ip_rvalid", 32'(o_ip_rvalid), 32'd1);
    chk("t1_ip_rdata", o_ip_rdata, 32'hDEAD_BEEF);
    chk("t1_dp_rvalid", 32'(o_dp_rvalid), 32'd0); tick();
    i_dp_arvalid = 1'b1; i_dp_araddr = 32'h0000_0040;
    settle(); chk("t1_next_issue", 32'(o_dp_arready), 32'd1); tick();
    repeat (3) step();

    // Simultaneous requests from reset, twice.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      i_ip_arvalid = 1'b1; i_ip_araddr = 32'h100;
      i_dp_arvalid = 1'b1; i_dp_araddr = 32'h200;
      settle(); chk("t2_dp_wins", 32'(o_dp_arready), 32'd1);
      chk("t2_ip_waits", 32'(o_ip_arready), 32'd0); tick();
      settle(); chk("t2_first_addr", o_mem_araddr, 32'h200); tick();
      step();
      settle(); chk("t2_ip_granted", 32'(o_ip_arready), 32'd1); tick();
      settle(); chk("t2_second_addr", o_mem_araddr, 32'h100); tick();
      step();
    end
    // Data read alone, then a conflict: only round-robin lets the fetch side through.
    i_dp_arvalid = 1'b1; i_dp_araddr = 32'h240;
    repeat (3) step();
    i_ip_arvalid = 1'b1; i_ip_araddr = 32'h140;
    i_dp_arvalid = 1'b1; i_dp_araddr = 32'h280;
    settle();
`ifdef RV32_ARB_ROUND_ROBIN_EN
    chk("t2_rr_ip_wins", 32'(o_ip_arready), 32'd1);
`else
    chk("t2_fixed_dp_wins", 32'(o_dp_arready), 32'd1);
`endif
    tick();
    repeat (6) step();

    // Memory stalls arready for 4 cycles.
    mem_hold = 1'b1;
    i_ip_arvalid = 1'b1; i_ip_araddr = 32'h0000_0ABC; i_ip_arprot = 3'b101;
    step();
    i_dp_arvalid = 1'b1; i_dp_araddr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("t3_araddr_stable", o_mem_araddr, 32'h0000_0ABC);
      chk("t3_arprot_stable", 32'(o_mem_arprot), 32'd5);
      chk("t3_arvalid_held", 32'(o_mem_arvalid), 32'd1);
      chk("t3_no_arready", {30'd0, o_ip_arready, o_dp_arready}, 32'd0);
      tick();
    end
    mem_hold = 1'b0; i_mem_arready = 1'b1;
    repeat (6) step();

    // Fetch side holds rready low while memory presents data.
    mem_data = 32'h1234_5678; i_ip_rready = 1'b0;
    i_ip_arvalid = 1'b1; i_ip_araddr = 32'h180;
    repeat (2) step();
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t4_mem_rready_low", 32'(o_mem_rready), 32'd0);
      chk("t4_ip_rvalid", 32'(o_ip_rvalid), 32'd1);
      tick();
    end
    i_ip_rready = 1'b1;
    settle(); chk("t4_mem_rready", 32'(o_mem_rready), 32'd1);
    chk("t4_ip_rdata", o_ip_rdata, 32'h1234_5678); tick();
    i_dp_arvalid = 1'b1; i_dp_araddr = 32'h1C0;
    settle(); chk("t4_idle_after", 32'(o_dp_arready), 32'd1); tick();
    repeat (3) step();

    // Data write while a fetch read is outstanding.
    mem_hold = 1'b1; mem_data = 32'hCAFE_F00D;
    i_ip_arvalid = 1'b1; i_ip_araddr = 32'h3C0;
    step();
    i_dp_awvalid = 1'b1; i_dp_awaddr = 32'h300; i_dp_wvalid = 1'b1;
    i_dp_wdata = 32'hA5A5_A5A5; i_dp_wstrb = 4'hF;
    i_mem_awready = 1'b1; i_mem_wready = 1'b1;
    settle();
    chk("t5_mem_awaddr", o_mem_awaddr, 32'h300);
    chk("t5_mem_wdata", o_mem_wdata, 32'hA5A5_A5A5);
    chk("t5_dp_aw_w_ready", {30'd0, o_dp_awready, o_dp_wready}, 32'd3);
    chk("t5_read_held", 32'(o_mem_arvalid), 32'd1);
    tick();
    i_dp_awvalid = 1'b0; i_dp_wvalid = 1'b0;
    i_mem_bvalid = 1'b1; i_mem_bresp = 2'b00; i_dp_bready = 1'b1;
    settle();
    chk("t5_dp_bvalid", 32'(o_dp_bvalid), 32'd1);
    chk("t5_dp_bresp", 32'(o_dp_bresp), 32'd0);
    tick();
    i_mem_bvalid = 1'b0; mem_hold = 1'b0; i_mem_arready = 1'b1;
    step();
    settle(); chk("t5_ip_rvalid", 32'(o_ip_rvalid), 32'd1);
    chk("t5_read_data", o_ip_rdata, 32'hCAFE_F00D); tick();
    step();

    // Reset while in the address phase.
    mem_hold = 1'b1;
    i_ip_arvalid = 1'b1; i_ip_araddr = 32'h440;
    step();
    settle(); chk("t6_in_addr", 32'(o_mem_arvalid), 32'd1); tick();
    aresetn = 1'b0;
    step();
    aresetn = 1'b1; mem_hold = 1'b0; i_mem_arready = 1'b1;
    settle();
    chk("t6_arvalid_cleared", 32'(o_mem_arvalid), 32'd0);
    chk("t6_no_arready", {30'd0, o_ip_arready, o_dp_arready}, 32'd0);
    tick();
    i_dp_arvalid = 1'b1; i_dp_araddr = 32'h500;
    settle(); chk("t6_regrant", 32'(o_dp_arready), 32'd1); tick();
    settle(); chk("t6_new_addr", o_mem_araddr, 32'h500); tick();
    repeat (2) step();

    // Random traffic on every channel.
    rand_en = 1'b1;
    repeat (3000) step();
    rand_en = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
